// File: rtl/seq_lock_gen.sv
// Serial combination lock: compares a full CODE_LEN-symbol entry against a programmable code,
// with failed-attempt lockout, entry timeout, explicit relock and a 7-segment status digit.
module seq_lock_gen #(
  parameter int SYM_W        = 2,
  parameter int CODE_LEN     = 6,
  parameter logic [CODE_LEN*SYM_W-1:0] DEFAULT_CODE = 12'hF3C,
  parameter int MAX_FAIL     = 3,
  parameter int LOCKOUT_CYC  = 16,
  parameter int TIMEOUT_CYC  = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enter,
  input  logic [SYM_W-1:0]                    sym,
  input  logic                                clear,
  input  logic                                relock,
  input  logic                                prog,
  output logic                                unlocked,
  output logic                                lockout,
  output logic [6:0]                          seg_disp,
  output logic [$clog2(CODE_LEN+1)-1:0]       digits,
  output logic [$clog2(MAX_FAIL+1)-1:0]       fail_cnt
);
  localparam int BW = CODE_LEN * SYM_W;
  localparam int DW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);

  localparam logic [6:0] SEG_L = 7'b1000111;
  localparam logic [6:0] SEG_U = 7'b1000001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_P = 7'b0001100;

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_UNLOCKED, S_PROG, S_LOCKOUT} state_t;

  state_t          state;
  logic [BW-1:0]   code;
  logic [BW-1:0]   shift_buf;
  logic [TW-1:0]   tmo_cnt;
  logic [LW-1:0]   lock_cnt;

  logic [BW-1:0]   buf_shift;
  logic            last_sym;
  logic            tmo_hit;

  assign buf_shift = {shift_buf[BW-SYM_W-1:0], sym};
  assign last_sym  = (digits == DW'(CODE_LEN - 1));
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // {unlocked, lockout, seg_disp} for the state being entered, so outputs stay registered
  function automatic logic [8:0] outs(input state_t s);
    case (s)
      S_UNLOCKED: outs = {1'b1, 1'b0, SEG_U};
      S_PROG:     outs = {1'b0, 1'b0, SEG_P};
      S_LOCKOUT:  outs = {1'b0, 1'b1, SEG_E};
      default:    outs = {1'b0, 1'b0, SEG_L};
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                          <= S_IDLE;
      code                           <= DEFAULT_CODE;
      shift_buf                      <= '0;
      digits                         <= '0;
      fail_cnt                       <= '0;
      tmo_cnt                        <= '0;
      lock_cnt                       <= '0;
      {unlocked, lockout, seg_disp}  <= outs(S_IDLE);
    end else begin
      case (state)
        S_IDLE, S_ENTRY: begin
          if (clear) begin
            state                         <= S_IDLE;
            {unlocked, lockout, seg_disp} <= outs(S_IDLE);
            digits                        <= '0;
            tmo_cnt                       <= '0;
          end else if (enter) begin
            shift_buf <= buf_shift;
            tmo_cnt   <= '0;
            if (last_sym) begin
              // compare includes the symbol arriving this cycle
              digits <= '0;
              if (buf_shift == code) begin
                state                         <= S_UNLOCKED;
                {unlocked, lockout, seg_disp} <= outs(S_UNLOCKED);
                fail_cnt                      <= '0;
              end else if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                state                         <= S_LOCKOUT;
                {unlocked, lockout, seg_disp} <= outs(S_LOCKOUT);
                fail_cnt                      <= fail_cnt + FW'(1);
                lock_cnt                      <= LW'(LOCKOUT_CYC - 1);
              end else begin
                state                         <= S_IDLE;
                {unlocked, lockout, seg_disp} <= outs(S_IDLE);
                fail_cnt                      <= fail_cnt + FW'(1);
              end
            end else begin
              digits                        <= digits + DW'(1);
              state                         <= S_ENTRY;
              {unlocked, lockout, seg_disp} <= outs(S_ENTRY);
            end
          end else if (state == S_ENTRY) begin
            if (tmo_hit) begin
              state                         <= S_IDLE;
              {unlocked, lockout, seg_disp} <= outs(S_IDLE);
              digits                        <= '0;
              tmo_cnt                       <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
        end

        S_UNLOCKED: begin
          if (relock) begin
            state                         <= S_IDLE;
            {unlocked, lockout, seg_disp} <= outs(S_IDLE);
          end else if (prog) begin
            state                         <= S_PROG;
            {unlocked, lockout, seg_disp} <= outs(S_PROG);
            digits                        <= '0;
            tmo_cnt                       <= '0;
          end
        end

        S_PROG: begin
          if (clear) begin
            state                         <= S_UNLOCKED;
            {unlocked, lockout, seg_disp} <= outs(S_UNLOCKED);
            digits                        <= '0;
            tmo_cnt                       <= '0;
          end else if (enter) begin
            shift_buf <= buf_shift;
            tmo_cnt   <= '0;
            if (last_sym) begin
              code                          <= buf_shift;
              digits                        <= '0;
              state                         <= S_IDLE;
              {unlocked, lockout, seg_disp} <= outs(S_IDLE);
            end else begin
              digits <= digits + DW'(1);
            end
          end else if (tmo_hit) begin
            state                         <= S_UNLOCKED;
            {unlocked, lockout, seg_disp} <= outs(S_UNLOCKED);
            digits                        <= '0;
            tmo_cnt                       <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_LOCKOUT: begin
          // loaded with LOCKOUT_CYC-1 so lockout is high for exactly LOCKOUT_CYC clocks
          if (lock_cnt == '0) begin
            state                         <= S_IDLE;
            {unlocked, lockout, seg_disp} <= outs(S_IDLE);
            fail_cnt                      <= '0;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end

        default: begin
          state                         <= S_IDLE;
          {unlocked, lockout, seg_disp} <= outs(S_IDLE);
          digits                        <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_lock_gen.sv
// Directed bench for seq_lock_gen: unlock, lockout, timeout, programming, relock and async reset.
module tb_seq_lock_gen;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic [1:0] sym   = 2'd0;
  logic       clear = 1'b0;
  logic       relock = 1'b0;
  logic       prog  = 1'b0;
  logic       unlocked;
  logic       lockout;
  logic [6:0] seg_disp;
  logic [2:0] digits;
  logic [1:0] fail_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] SEG_L = 7'b1000111;
  localparam logic [6:0] SEG_U = 7'b1000001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_P = 7'b0001100;

  seq_lock_gen dut (
    .clock    (clock),
    .reset    (reset),
    .enter    (enter),
    .sym      (sym),
    .clear    (clear),
    .relock   (relock),
    .prog     (prog),
    .unlocked (unlocked),
    .lockout  (lockout),
    .seg_disp (seg_disp),
    .digits   (digits),
    .fail_cnt (fail_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_sym(input logic [1:0] s);
    enter = 1'b1;
    sym   = s;
    tick();
    enter = 1'b0;
  endtask

  task automatic put_code(input logic [11:0] c);
    logic [11:0] v;
    v = c;
    for (int i = 5; i >= 0; i--) put_sym(v[2*i +: 2]);
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_unlocked", unlocked, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_seg", seg_disp, SEG_L);
    chk("rst_digits", digits, 0);
    chk("rst_fail", fail_cnt, 0);
    reset = 1'b1;
    tick();

    // default code 3,3,0,3,3,0
    put_sym(2'd3); put_sym(2'd3); put_sym(2'd0);
    chk("entry_digits3", digits, 3);
    put_sym(2'd3); put_sym(2'd3);
    chk("entry_not_yet", unlocked, 0);
    put_sym(2'd0);
    chk("unlock_flag", unlocked, 1);
    chk("unlock_seg", seg_disp, SEG_U);
    chk("unlock_digits", digits, 0);
    chk("unlock_fail", fail_cnt, 0);
    put_sym(2'd1);
    chk("unlocked_enter_ign", digits, 0);

    relock = 1'b1; tick(); relock = 1'b0;
    chk("relock_flag", unlocked, 0);
    chk("relock_seg", seg_disp, SEG_L);

    // three wrong entries -> lockout
    put_code(12'hF3D);
    chk("fail1", fail_cnt, 1);
    chk("fail1_seg", seg_disp, SEG_L);
    put_code(12'hF3D);
    chk("fail2", fail_cnt, 2);
    put_code(12'hF3D);
    chk("lock_flag", lockout, 1);
    chk("lock_seg", seg_disp, SEG_E);
    chk("lock_fail", fail_cnt, 3);
    enter = 1'b1; sym = 2'd3;
    for (int i = 0; i < 15; i++) tick();
    chk("lock_hold15", lockout, 1);
    chk("lock_enter_ign", digits, 0);
    enter = 1'b0;
    tick();
    chk("lock_exit", lockout, 0);
    chk("lock_exit_seg", seg_disp, SEG_L);
    chk("lock_exit_fail", fail_cnt, 0);

    // clear beats enter
    put_sym(2'd3); put_sym(2'd3);
    clear = 1'b1; enter = 1'b1; sym = 2'd0; tick();
    clear = 1'b0; enter = 1'b0;
    chk("clear_digits", digits, 0);

    // timeout with fail_cnt preserved
    put_code(12'h000);
    chk("tmo_pre_fail", fail_cnt, 1);
    put_sym(2'd3); put_sym(2'd3); put_sym(2'd0);
    for (int i = 0; i < 31; i++) tick();
    chk("tmo_31", digits, 3);
    tick();
    chk("tmo_32", digits, 0);
    chk("tmo_fail", fail_cnt, 1);
    put_code(12'hF3C);
    chk("tmo_unlock", unlocked, 1);
    chk("tmo_unlock_fail", fail_cnt, 0);

    // program 1,2,3,0,1,2 = 12'h6C6
    prog = 1'b1; tick(); prog = 1'b0;
    chk("prog_seg", seg_disp, SEG_P);
    chk("prog_unlocked", unlocked, 0);
    put_code(12'h6C6);
    chk("prog_done_seg", seg_disp, SEG_L);
    chk("prog_done_digits", digits, 0);
    put_code(12'hF3C);
    chk("old_code_fail", fail_cnt, 1);
    chk("old_code_locked", unlocked, 0);
    put_code(12'h6C6);
    chk("new_code_unlock", unlocked, 1);

    // relock + prog together: relock wins
    relock = 1'b1; prog = 1'b1; tick(); relock = 1'b0; prog = 1'b0;
    chk("relock_prog_seg", seg_disp, SEG_L);
    put_code(12'h6C6);
    chk("code_kept", unlocked, 1);

    // clear in PROG returns to UNLOCKED
    prog = 1'b1; tick(); prog = 1'b0;
    put_sym(2'd0); put_sym(2'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("prog_clear_seg", seg_disp, SEG_U);
    chk("prog_clear_digits", digits, 0);

    // async reset mid-PROG restores default code
    prog = 1'b1; tick(); prog = 1'b0;
    put_sym(2'd0); put_sym(2'd0); put_sym(2'd0); put_sym(2'd0);
    chk("prog4_digits", digits, 4);
    reset = 1'b0;
    #1;
    chk("arst_digits", digits, 0);
    chk("arst_seg", seg_disp, SEG_L);
    chk("arst_unlocked", unlocked, 0);
    tick();
    reset = 1'b1;
    tick();
    put_code(12'hF3C);
    chk("arst_default_code", unlocked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
